logic_unit_pipe: RTL and testbench

Parametrised, pipelined successor to the team's single-bit two-input gates. Applies one of eight bitwise logic functions to WIDTH-bit operands. Operand B can be taken from an internal accumulator, so a stream can be reduced (for example, the running XOR or XNOR of a stream). Valid/ready handshakes on both sides, with a 2-entry output buffer that sustains 1 beat per cycle. Sits between a producer and a consumer stage in the datapath.

---
 rtl/logic_unit_pipe_if.sv | 28 ++
 rtl/logic_unit_pipe.sv | 83 ++++++++
 tb/tb_logic_unit_pipe.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_pipe_if.sv
// Handshake bundle for logic_unit_pipe: producer-side operands plus the
// consumer-side result/flags, with modports for the driving and receiving ends.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_en;
  logic             acc_clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             out_zero;
  logic             out_parity;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, op, acc_en, acc_clr, in_valid, out_ready,
    input  in_ready, out, out_zero, out_parity, out_valid
  );

  modport slave (
    input  a, b, op, acc_en, acc_clr, in_valid, out_ready,
    output in_ready, out, out_zero, out_parity, out_valid
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with an accumulator feedback operand
// and a 2-entry output FIFO carrying {result, zero, parity}.
module logic_unit_pipe #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input logic               clk,
  input logic               rst_n,
  logic_unit_pipe_if.slave  bus
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_accop;
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH+1:0] r_mem [2];
  logic [1:0]       r_count;
  logic             r_rd;
  logic             r_wr;
  logic             w_push;
  logic             w_pop;

  assign w_accop = bus.acc_clr ? ACC_INIT : r_acc;
  assign w_opb   = bus.acc_en ? w_accop : bus.b;

  always_comb begin
    w_result = bus.a;
    case (bus.op)
      3'd0:    w_result = bus.a & w_opb;
      3'd1:    w_result = bus.a | w_opb;
      3'd2:    w_result = bus.a ^ w_opb;
      3'd3:    w_result = ~(bus.a ^ w_opb);
      3'd4:    w_result = ~(bus.a & w_opb);
      3'd5:    w_result = ~(bus.a | w_opb);
      3'd6:    w_result = ~bus.a;
      default: w_result = bus.a;
    endcase
  end

  // in_ready depends only on the registered count, never on out_ready.
  assign bus.in_ready  = (r_count < 2'd2);
  assign bus.out_valid = (r_count != 2'd0);
  assign w_push        = bus.in_valid & bus.in_ready;
  assign w_pop         = bus.out_valid & bus.out_ready;

  assign {bus.out, bus.out_zero, bus.out_parity} = r_mem[r_rd];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem[gi] <= '0;
        end else if (w_push && (r_wr == 1'(gi))) begin
          r_mem[gi] <= {w_result, ~|w_result, ^w_result};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= ACC_INIT;
      r_count <= 2'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      if (w_push) begin
        r_acc <= w_result;
        r_wr  <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      // A push and pop in the same cycle leave the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and random stimulus for logic_unit_pipe, checked against a queue
// model of the output buffer and a behavioural accumulator.
module tb_logic_unit_pipe;
  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] ACC_INIT = '0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(WIDTH)) bus ();

  logic_unit_pipe #(.WIDTH(WIDTH), .ACC_INIT(ACC_INIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_acc = ACC_INIT;

  function automatic logic [WIDTH-1:0] ref_f(input logic [2:0] op,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    case (op)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x ^ y);
      3'd4:    return ~(x & y);
      3'd5:    return ~(x | y);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("out", 32'(bus.out), 32'(q[0]));
      chk("out_zero", 32'(bus.out_zero), 32'(q[0] == '0));
      chk("out_parity", 32'(bus.out_parity), 32'(^q[0]));
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [2:0] op, input logic acc_en, input logic acc_clr,
                       input logic valid, input logic ordy);
    bus.a = a; bus.b = b; bus.op = op; bus.acc_en = acc_en; bus.acc_clr = acc_clr;
    bus.in_valid = valid; bus.out_ready = ordy;
  endtask

  // One clock: decide accept/pop from the model, advance, then compare.
  task automatic cycle();
    bit acc_ok;
    bit pop_ok;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] r;
    acc_ok = bus.in_valid && (q.size() < 2);
    pop_ok = (q.size() > 0) && bus.out_ready;
    r = '0;
    if (acc_ok) begin
      opb = bus.acc_en ? (bus.acc_clr ? ACC_INIT : m_acc) : bus.b;
      r = ref_f(bus.op, bus.a, opb);
      $display("beat a=%02h b=%02h op=%0d acc_en=%0b acc_clr=%0b -> %02h",
               bus.a, bus.b, bus.op, bus.acc_en, bus.acc_clr, r);
    end
    @(posedge clk);
    #1;
    if (pop_ok) void'(q.pop_front());
    if (acc_ok) begin
      q.push_back(r);
      m_acc = r;
    end
    chk_model();
  endtask

  initial begin
    drive('0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_zero", 32'(bus.out_zero), 32'd0);
    chk("rst_parity", 32'(bus.out_parity), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // XNOR
    drive(8'hA5, 8'h0F, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1); cycle();
    chk("xnor_out", 32'(bus.out), 32'h55);
    chk("xnor_zero", 32'(bus.out_zero), 32'd0);
    chk("xnor_par", 32'(bus.out_parity), 32'd0);

    // NAND all ones
    drive(8'hFF, 8'hFF, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1); cycle();
    chk("nand_out", 32'(bus.out), 32'h00);
    chk("nand_zero", 32'(bus.out_zero), 32'd1);

    // Accumulated XOR stream
    drive(8'h01, 8'h00, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1); cycle();
    chk("accx1", 32'(bus.out), 32'h01);
    chk("accx1_par", 32'(bus.out_parity), 32'd1);
    drive(8'h02, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1); cycle();
    chk("accx2", 32'(bus.out), 32'h03);
    chk("accx2_par", 32'(bus.out_parity), 32'd0);
    drive(8'h04, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1); cycle();
    chk("accx3", 32'(bus.out), 32'h07);
    chk("accx3_par", 32'(bus.out_parity), 32'd1);
    chk("accx3_rdy", 32'(bus.in_ready), 32'd1);
    drive('0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1); cycle();

    // Backpressure
    drive(8'h11, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    drive(8'h22, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    drive(8'h33, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    chk("bp_full_rdy", 32'(bus.in_ready), 32'd0);
    chk("bp_head", 32'(bus.out), 32'h11);
    cycle();
    chk("bp_hold", 32'(bus.out), 32'h11);
    bus.out_ready = 1'b1; cycle();
    chk("bp_second", 32'(bus.out), 32'h22);
    chk("bp_rdy_back", 32'(bus.in_ready), 32'd1);
    cycle();
    chk("bp_third", 32'(bus.out), 32'h33);
    bus.in_valid = 1'b0; cycle();

    // Continuous stream with out_ready held high
    for (int i = 0; i < 30; i++) begin
      drive(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom_range(0, 3) == 0), 1'b1, 1'b1);
      cycle();
      chk("stream_rdy", 32'(bus.in_ready), 32'd1);
      chk("stream_valid", 32'(bus.out_valid), 32'd1);
    end

    // Fully random handshakes
    for (int i = 0; i < 300; i++) begin
      drive(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom), 1'($urandom));
      cycle();
    end

    // Reset mid-operation with a full buffer and acc=5A
    drive('0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1); cycle(); cycle();
    drive(8'h5A, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0); cycle(); cycle();
    chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_acc = ACC_INIT;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_rdy", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out", 32'(bus.out), 32'd0);
    #1;
    rst_n = 1'b1;
    drive(8'h0F, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1); cycle();
    chk("post_rst_acc", 32'(bus.out), 32'h0F);
    bus.in_valid = 1'b0; cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
